// File: rtl/result_pkg.sv
// ---------------------------------------------------------------------------
// result_pkg
// Shared constants and types for the result_filter temporal vote filter.
//   CLS_W       : width of a class code (8 oil classes)
//   NUM_CLS     : number of classes scanned per evaluation
//   CONF_W      : width of the confidence output
//   HYST_MARGIN : lead a challenger needs over the last sent verdict when
//                 the RESULT_FILTER_HYST_EN build option is enabled
//   state_e     : controller FSM states
// ---------------------------------------------------------------------------
package result_pkg;

    localparam int CLS_W       = 3;
    localparam int NUM_CLS     = 8;
    localparam int CONF_W      = 5;
    localparam int HYST_MARGIN = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UPD  = 2'd1,
        EVAL = 2'd2,
        SEND = 2'd3
    } state_e;

endpackage

// File: rtl/result_hist.sv
// ---------------------------------------------------------------------------
// result_hist
// Sliding window history of the last WIN class results with one occurrence
// counter per class.
//   clk, rst_n : clock, asynchronous active-low reset
//   ins        : insert ins_cls this cycle (single-cycle operation)
//   ins_cls    : class code to insert
//   rd_cls     : class whose counter is read
//   rd_cnt     : occurrences of rd_cls in the window (combinational read)
//   filled     : window holds WIN samples; also high during the insert that
//                brings the window to WIN samples
// ---------------------------------------------------------------------------
module result_hist
    import result_pkg::*;
#(
    parameter int WIN = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ins,
    input  logic [CLS_W-1:0]             ins_cls,
    input  logic [CLS_W-1:0]             rd_cls,
    output logic [$clog2(WIN+1)-1:0]     rd_cnt,
    output logic                         filled
);

    localparam int CNT_W = $clog2(WIN + 1);
    localparam int PTR_W = (WIN > 1) ? $clog2(WIN) : 1;

    logic [CLS_W-1:0] hist [WIN];
    logic [PTR_W-1:0] wptr;
    logic [CNT_W-1:0] fill;
    logic [CNT_W-1:0] cnt [NUM_CLS];
    logic             full;
    logic [CLS_W-1:0] evict;

    assign full   = (fill == CNT_W'(WIN));
    // The entry under the write pointer is the oldest one once the window
    // is full; it is the one that falls out on this insert.
    assign evict  = hist[wptr];
    assign rd_cnt = cnt[rd_cls];
    assign filled = full | (ins & (fill == CNT_W'(WIN - 1)));

    // Buffer contents need no reset: fill gates every use of stale entries.
    always_ff @(posedge clk) begin
        if (ins) begin
            hist[wptr] <= ins_cls;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            fill <= '0;
        end else if (ins) begin
            wptr <= (wptr == PTR_W'(WIN - 1)) ? '0 : wptr + 1'b1;
            if (!full) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Incoming class counts up, evicted class counts down; when both are the
    // same class the two cancel and the counter is left alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CLS; c++) begin
                cnt[c] <= '0;
            end
        end else if (ins) begin
            for (int c = 0; c < NUM_CLS; c++) begin
                if ((ins_cls == CLS_W'(c)) && !(full && (evict == CLS_W'(c)))) begin
                    cnt[c] <= cnt[c] + 1'b1;
                end else if ((ins_cls != CLS_W'(c)) && full && (evict == CLS_W'(c))) begin
                    cnt[c] <= cnt[c] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/result_filter.sv
// ---------------------------------------------------------------------------
// result_filter
// Temporal majority-vote filter for per-frame oil-class results. Each frame
// result is inserted into a WIN-deep sliding window, the eight class counters
// are scanned one per cycle for the majority class, and the verdict is
// offered to the sink over valid/ready.
//
// Handshake: out_valid rises with verdict/confidence/changed already stable,
// stays high with those outputs frozen until a cycle with out_ready high,
// and drops on the following cycle. It never drops without a transfer.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   frame_end   : one-cycle strobe qualifying result
//   result      : per-frame class code 0..7
//   out_valid   : verdict pending for the sink
//   out_ready   : sink accepts the verdict
//   verdict     : majority class
//   confidence  : occurrences of verdict in the window
//   changed     : verdict differs from the last sent one (or first verdict)
//   filled      : window holds WIN samples (sticky until reset)
//   overrun     : sticky, a pending frame sample was lost
//
// Build option RESULT_FILTER_HYST_EN: once a verdict has been sent, a new
// winner only displaces it when it leads by HYST_MARGIN occurrences.
// ---------------------------------------------------------------------------
module result_filter
    import result_pkg::*;
#(
    parameter int WIN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_end,
    input  logic [CLS_W-1:0]  result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CLS_W-1:0]  verdict,
    output logic [CONF_W-1:0] confidence,
    output logic              changed,
    output logic              filled,
    output logic              overrun
);

    localparam int CNT_W = $clog2(WIN + 1);

    state_e           state;
    logic [CLS_W-1:0] samp;
    logic             pend_vld;
    logic [CLS_W-1:0] pend_val;
    logic [CLS_W-1:0] scan_idx;
    logic [CLS_W-1:0] best_cls;
    logic [CNT_W-1:0] best_cnt;
    logic [CLS_W-1:0] last_sent;
    logic             have_sent;

    logic             ins;
    logic [CNT_W-1:0] rd_cnt;
    logic             take;
    logic [CLS_W-1:0] nb_cls;
    logic [CNT_W-1:0] nb_cnt;
    logic [CLS_W-1:0] sel_cls;
    logic [CNT_W-1:0] sel_cnt;

    assign ins = (state == UPD);

    result_hist #(.WIN(WIN)) u_hist (
        .clk     (clk),
        .rst_n   (rst_n),
        .ins     (ins),
        .ins_cls (samp),
        .rd_cls  (scan_idx),
        .rd_cnt  (rd_cnt),
        .filled  (filled)
    );

    // Strictly-greater replacement keeps the lowest class index on ties.
    assign take   = (rd_cnt > best_cnt);
    assign nb_cls = take ? scan_idx : best_cls;
    assign nb_cnt = take ? rd_cnt   : best_cnt;

`ifdef RESULT_FILTER_HYST_EN
    // Count of the last sent class, picked up as the scan passes it.
    logic [CNT_W-1:0] ls_cnt;
    logic [CNT_W-1:0] ls_now;
    logic [CNT_W:0]   ls_thr;

    assign ls_now = (scan_idx == last_sent) ? rd_cnt : ls_cnt;
    assign ls_thr = {1'b0, ls_now} + (CNT_W + 1)'(HYST_MARGIN);

    always_comb begin
        sel_cls = nb_cls;
        sel_cnt = nb_cnt;
        if (have_sent && ({1'b0, nb_cnt} < ls_thr)) begin
            sel_cls = last_sent;
            sel_cnt = ls_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ls_cnt <= '0;
        end else if (state == EVAL && scan_idx == last_sent) begin
            ls_cnt <= rd_cnt;
        end
    end
`else
    always_comb begin
        sel_cls = nb_cls;
        sel_cnt = nb_cnt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            samp       <= '0;
            pend_vld   <= 1'b0;
            pend_val   <= '0;
            overrun    <= 1'b0;
            scan_idx   <= '0;
            best_cls   <= '0;
            best_cnt   <= '0;
            last_sent  <= '0;
            have_sent  <= 1'b0;
            out_valid  <= 1'b0;
            verdict    <= '0;
            confidence <= '0;
            changed    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_end) begin
                        // A live frame wins over a pending one; the pending
                        // sample is dropped and flagged.
                        samp  <= result;
                        state <= UPD;
                        if (pend_vld) begin
                            overrun  <= 1'b1;
                            pend_vld <= 1'b0;
                        end
                    end else if (pend_vld) begin
                        samp     <= pend_val;
                        pend_vld <= 1'b0;
                        state    <= UPD;
                    end
                end
                UPD: begin
                    best_cls <= '0;
                    best_cnt <= '0;
                    scan_idx <= '0;
                    state    <= EVAL;
                end
                EVAL: begin
                    best_cls <= nb_cls;
                    best_cnt <= nb_cnt;
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_idx == CLS_W'(NUM_CLS - 1)) begin
                        if (filled) begin
                            state      <= SEND;
                            out_valid  <= 1'b1;
                            verdict    <= sel_cls;
                            confidence <= CONF_W'(sel_cnt);
                            changed    <= !have_sent || (sel_cls != last_sent);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        last_sent <= verdict;
                        have_sent <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Frames arriving while busy park in the one-entry pending slot.
            if (frame_end && state != IDLE) begin
                if (pend_vld) begin
                    overrun <= 1'b1;
                end
                pend_vld <= 1'b1;
                pend_val <= result;
            end
        end
    end

endmodule

// File: tb/tb_result_filter.sv
// ---------------------------------------------------------------------------
// tb_result_filter
// Directed bench for result_filter (WIN=8). Expected values are worked out
// by hand from the window contents at each step. Honors the
// RESULT_FILTER_HYST_EN build option for the steps where it matters.
// ---------------------------------------------------------------------------
module tb_result_filter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_end = 1'b0;
    logic [2:0] result = 3'd0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [2:0] verdict;
    logic [4:0] confidence;
    logic       changed;
    logic       filled;
    logic       overrun;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    result_filter #(.WIN(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_end  (frame_end),
        .result     (result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .verdict    (verdict),
        .confidence (confidence),
        .changed    (changed),
        .filled     (filled),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] r);
        frame_end = 1'b1;
        result    = r;
        tick(1);
        frame_end = 1'b0;
    endtask

    // One frame from IDLE: out_valid must stay low through t+9 and match
    // exp_out at t+10; one extra cycle lets the transfer complete.
    task automatic run_frame(input string tag, input logic [2:0] r, input logic exp_out,
                             input logic [2:0] ev, input logic [4:0] ec, input logic ech);
        pulse(r);
        tick(8);
        check({tag, " early"}, 32'(out_valid), 32'(1'b0));
        tick(1);
        check({tag, " valid"}, 32'(out_valid), 32'(exp_out));
        if (exp_out) begin
            check({tag, " verdict"}, 32'(verdict), 32'(ev));
            check({tag, " conf"}, 32'(confidence), 32'(ec));
            check({tag, " changed"}, 32'(changed), 32'(ech));
        end
        tick(1);
    endtask

    initial begin
        int drops;
        int w;
        int rises;

        // Reset state
        tick(2);
        check("rst out_valid", 32'(out_valid), 32'(1'b0));
        check("rst verdict", 32'(verdict), 32'(3'd0));
        check("rst conf", 32'(confidence), 32'(5'd0));
        check("rst changed", 32'(changed), 32'(1'b0));
        check("rst filled", 32'(filled), 32'(1'b0));
        check("rst overrun", 32'(overrun), 32'(1'b0));
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(1);

        // Fill with 5s; first verdict only on the 8th frame
        for (int i = 0; i < 7; i++) run_frame("pre5", 3'd5, 1'b0, 3'd0, 5'd0, 1'b0);
        check("pre filled low", 32'(filled), 32'(1'b0));
        run_frame("pre5 8th", 3'd5, 1'b1, 3'd5, 5'd8, 1'b1);
        check("pre filled", 32'(filled), 32'(1'b1));
        run_frame("pre5 9th", 3'd5, 1'b1, 3'd5, 5'd8, 1'b0);

        // Reset in the middle of EVAL
        pulse(3'd5);
        tick(4);
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'(1'b0));
        check("mid rst verdict", 32'(verdict), 32'(3'd0));
        check("mid rst conf", 32'(confidence), 32'(5'd0));
        check("mid rst changed", 32'(changed), 32'(1'b0));
        check("mid rst filled", 32'(filled), 32'(1'b0));
        check("mid rst overrun", 32'(overrun), 32'(1'b0));
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Eight fresh frames of 5; changed set again since reset
        for (int i = 0; i < 7; i++) run_frame("post5", 3'd5, 1'b0, 3'd0, 5'd0, 1'b0);
        run_frame("post5 8th", 3'd5, 1'b1, 3'd5, 5'd8, 1'b1);

        // Four 3s into a window of 5s
        run_frame("three 1", 3'd3, 1'b1, 3'd5, 5'd7, 1'b0);
        run_frame("three 2", 3'd3, 1'b1, 3'd5, 5'd6, 1'b0);
        run_frame("three 3", 3'd3, 1'b1, 3'd5, 5'd5, 1'b0);
`ifdef RESULT_FILTER_HYST_EN
        run_frame("three 4", 3'd3, 1'b1, 3'd5, 5'd4, 1'b0);
        run_frame("three 5", 3'd3, 1'b1, 3'd3, 5'd5, 1'b1);
`else
        run_frame("three 4", 3'd3, 1'b1, 3'd3, 5'd4, 1'b1);
        run_frame("three 5", 3'd3, 1'b1, 3'd3, 5'd5, 1'b0);
`endif

        // Back-pressure: window 3x5,5x2,1x1 after this frame
        out_ready = 1'b0;
        pulse(3'd1);
        tick(9);
        check("bp valid", 32'(out_valid), 32'(1'b1));
        check("bp verdict", 32'(verdict), 32'(3'd3));
        check("bp conf", 32'(confidence), 32'(5'd5));
        check("bp changed", 32'(changed), 32'(1'b0));
        check("bp overrun pre", 32'(overrun), 32'(1'b0));
        tick(2);
        pulse(3'd6);
        tick(3);
        check("bp overrun one", 32'(overrun), 32'(1'b0));
        pulse(3'd4);
        tick(1);
        check("bp overrun", 32'(overrun), 32'(1'b1));
        drops = 0;
        for (int i = 0; i < 22; i++) begin
            tick(1);
            if (out_valid !== 1'b1 || verdict !== 3'd3 || confidence !== 5'd5) drops++;
        end
        check("bp held", 32'(drops), 32'd0);
        out_ready = 1'b1;
        tick(1);
        check("bp drop", 32'(out_valid), 32'(1'b0));

        // Only the second parked sample (4) is processed: 3x5,1,4,5
        w = 0;
        while (out_valid !== 1'b1 && w < 20) begin
            tick(1);
            w++;
        end
        check("pend latency", 32'(w), 32'd10);
        check("pend verdict", 32'(verdict), 32'(3'd3));
        check("pend conf", 32'(confidence), 32'(5'd5));
        check("pend changed", 32'(changed), 32'(1'b0));
        rises = 0;
        tick(1);
        for (int i = 0; i < 15; i++) begin
            if (out_valid === 1'b1) rises++;
            tick(1);
        end
        check("pend single", 32'(rises), 32'd0);
        check("overrun sticky", 32'(overrun), 32'(1'b1));
        // Window becomes 3x5,1,4x2: a lost 6 would have evicted another 5
        run_frame("after pend", 3'd4, 1'b1, 3'd3, 5'd5, 1'b0);

        // Clean restart, then alternating 0/7 across the pointer wrap
        rst_n = 1'b0;
        tick(1);
        check("rst2 overrun", 32'(overrun), 32'(1'b0));
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) begin
            if (i < 7) run_frame("alt fill", (i % 2 == 1) ? 3'd7 : 3'd0, 1'b0, 3'd0, 5'd0, 1'b0);
            else       run_frame("alt tie", (i % 2 == 1) ? 3'd7 : 3'd0, 1'b1, 3'd0, 5'd4, (i == 7));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
